frame_window_compare: RTL and testbench
=======================================

Name: frame_window_compare

Overview:
- Multi-channel successor to the single-channel blank-driven count/compare controller in the VGA pipeline.
- Accumulates per-channel pixel "hit" counts during active video over a programmable window of whole frames.
- At each window end it latches the counts and compares each against a threshold, producing per-channel alarm flags and a one-cycle result strobe.
- Sits between the per-pixel detectors (motion/colour match) and the display/alarm logic.

Parameters:
- N_CH, 4, number of independent hit channels.
- CNT_W, 20, accumulator/result width per channel (bits).
- FRAMES, 1, frames per accumulation window (1..255).
- FIDX_W, 8, width of frame index output; must satisfy 2^FIDX_W >= FRAMES.

Ports:
- clk  in  1  system/pixel clock.
- reset  in  1  synchronous, active-low reset.
- iVGA_BLANK_N  in  1  high during active video.
- iVGA_VS_N  in  1  vertical sync, active-low; falling edge marks frame boundary.
- enable  in  1  run/stop.
- pix_hit  in  N_CH  per-channel hit flag for current pixel.
- threshold  in  CNT_W  common compare threshold, sampled in COMPARE cycle.
- count_out  out  N_CH*CNT_W  latched window counts, channel i at [i*CNT_W +: CNT_W].
- over_thresh  out  N_CH  latched flags: count_out[i] > threshold (strict).
- result_valid  out  1  one-cycle pulse when count_out/over_thresh update.
- frame_idx  out  FIDX_W  frame number within current window (0..FRAMES-1).
- busy  out  1  high in ARM, ACCUM, COMPARE.

Behaviour:
- Reset (reset==0 at posedge): state IDLE; accumulators, frame_idx, count_out, over_thresh, result_valid, busy all 0; vs_q set to 1.
- vs_q: iVGA_VS_N registered every cycle. vs_fall = vs_q & ~iVGA_VS_N (same cycle the input goes low).
- States:
  - IDLE: enable=1 -> ARM.
  - ARM: wait for frame alignment; on vs_fall -> ACCUM, frame_idx=0, accumulators=0. No counting in ARM.
  - ACCUM: each cycle with iVGA_BLANK_N=1 and pix_hit[i]=1, acc[i] += 1.
    - On vs_fall with frame_idx < FRAMES-1: frame_idx += 1, stay in ACCUM.
    - On vs_fall with frame_idx == FRAMES-1: -> COMPARE.
    - A hit coinciding with vs_fall is counted into the ending window.
  - COMPARE (exactly 1 cycle): at its closing edge, count_out[i] <= acc[i]; over_thresh[i] <= (acc[i] > threshold); result_valid <= 1; frame_idx <= 0; acc[i] <= hit term of this cycle (0 or 1). A hit in this cycle therefore belongs to the new window. Next state is ACCUM; no re-arm.
- result_valid is high in the cycle after COMPARE only; 0 otherwise.
- Saturation: acc[i] stops at 2^CNT_W-1; no wrap.
- enable=0 in any state: next state IDLE; accumulators and frame_idx cleared; count_out and over_thresh hold their last values; no result_valid. A partial window is discarded.
- enable rising while in IDLE always passes through ARM; the first window starts at the next vs_fall.
- busy = (state != IDLE), combinational from the state register.
- Mid-operation reset: identical to power-on reset; latched results cleared.
- threshold is only sampled in the COMPARE cycle; changes at other times have no effect.

Decomposition:
- Package frame_window_pkg: state enum typedef (IDLE, ARM, ACCUM, COMPARE) and a function computing saturating increment.
- Sub-module hit_accumulator (one CNT_W saturating counter with clear/load-with-hit, enable) instantiated N_CH times via generate.
- FSM, vs edge detect, frame counter and result latches stay in the top.

Test Plan:
- Reset/idle: reset=0 for 3 cycles, enable=0 -> all outputs 0, busy=0; vs pulses produce no result_valid.
- Single frame, N_CH=4, FRAMES=1, threshold=10: enable, vs_fall, then 12/10/0/11 hit cycles with BLANK_N=1 (plus 5 ch0 hits with BLANK_N=0), vs_fall -> one result_valid pulse, count_out={12,10,0,11}, over_thresh=4'b1001.
- Multi-frame, FRAMES=3: 4 hits on ch1 per frame -> result_valid only after third vs_fall; count_out ch1=12; frame_idx steps 0,1,2,0.
- Saturation, CNT_W=4: 20 ch2 hits in window -> count_out ch2=15, no wrap; threshold=14 -> over_thresh[2]=1.
- Boundary hits: hit on vs_fall cycle and on COMPARE cycle -> first counted in old window, second gives new window a count of 1.
- enable drop mid-window after 7 hits -> IDLE, no result_valid, prior count_out held; re-enable -> counting starts only after next vs_fall (ARM).

Source files
------------

// File: rtl/frame_window_pkg.sv
// Shared types and helpers for the frame-window hit counter/comparator.
package frame_window_pkg;

    // Controller states: idle, waiting for the first frame boundary,
    // accumulating hits, and the single result-latch cycle.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_ACCUM   = 2'd2,
        ST_COMPARE = 2'd3
    } state_t;

    // Widest counter the saturating helper supports.
    localparam int SAT_W = 32;

    // Increment that sticks at max_val instead of wrapping.
    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] val,
                                                 input logic [SAT_W-1:0] max_val);
        if (val >= max_val) begin
            return max_val;
        end
        return val + SAT_W'(1);
    endfunction

endpackage

// File: rtl/frame_window_compare_hit_accumulator.sv
// One saturating hit counter. Clear has priority over load, load over count.
// Load restarts the count at 0 or 1 depending on the hit of that cycle.
module hit_accumulator #(
    parameter int CNT_W = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic             inc_en_i,
    input  logic             hit_i,
    output logic [CNT_W-1:0] acc_o
);
    import frame_window_pkg::*;

    // All-ones at CNT_W, widened to the helper width (CNT_W <= 32).
    localparam logic [SAT_W-1:0] MAX_EXT = SAT_W'({CNT_W{1'b1}});

    logic [CNT_W-1:0] acc_q;
    logic [CNT_W-1:0] acc_d;

    // Next count: clear, restart with this cycle's hit, or saturating increment.
    always_comb begin
        acc_d = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (load_i) begin
            acc_d = CNT_W'(hit_i);
        end else if (inc_en_i && hit_i) begin
            acc_d = CNT_W'(sat_inc(SAT_W'(acc_q), MAX_EXT));
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/frame_window_compare.sv
// Multi-channel hit counter over a window of whole frames. At each window
// end the counts are latched, compared against a threshold, and announced
// with a one-cycle result_valid pulse.
module frame_window_compare #(
    parameter int N_CH   = 4,
    parameter int CNT_W  = 20,
    parameter int FRAMES = 1,
    parameter int FIDX_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    iVGA_BLANK_N,
    input  logic                    iVGA_VS_N,
    input  logic                    enable,
    input  logic [N_CH-1:0]         pix_hit,
    input  logic [CNT_W-1:0]        threshold,
    output logic [N_CH*CNT_W-1:0]   count_out,
    output logic [N_CH-1:0]         over_thresh,
    output logic                    result_valid,
    output logic [FIDX_W-1:0]       frame_idx,
    output logic                    busy
);
    import frame_window_pkg::*;

    localparam logic [FIDX_W-1:0] LAST_FRAME = FIDX_W'(FRAMES - 1);

    state_t                  state_q, state_d;
    logic                    vs_q;
    logic                    vs_fall;
    logic [FIDX_W-1:0]       frame_q, frame_d;
    logic                    acc_clear;
    logic                    acc_load;
    logic                    acc_count;
    logic                    latch_result;
    logic [N_CH-1:0]         hit_vec;
    logic [CNT_W-1:0]        acc [N_CH];
    logic [N_CH*CNT_W-1:0]   count_q, count_d;
    logic [N_CH-1:0]         over_q, over_d;
    logic                    valid_q;

    // Falling edge of vsync is seen in the same cycle the input goes low.
    assign vs_fall = vs_q & ~iVGA_VS_N;

    // Hits only count during active video.
    assign hit_vec = pix_hit & {N_CH{iVGA_BLANK_N}};

    // Register vsync for edge detection; idles high so reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            vs_q <= 1'b1;
        end else begin
            vs_q <= iVGA_VS_N;
        end
    end

    // Next-state, frame index and accumulator control. Dropping enable
    // always wins and discards any partial window.
    always_comb begin
        state_d      = state_q;
        frame_d      = frame_q;
        acc_clear    = 1'b0;
        acc_load     = 1'b0;
        acc_count    = 1'b0;
        latch_result = 1'b0;
        if (!enable) begin
            state_d   = ST_IDLE;
            frame_d   = '0;
            acc_clear = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d   = ST_ARM;
                    frame_d   = '0;
                    acc_clear = 1'b1;
                end
                ST_ARM: begin
                    if (vs_fall) begin
                        state_d   = ST_ACCUM;
                        frame_d   = '0;
                        acc_clear = 1'b1;
                    end
                end
                ST_ACCUM: begin
                    // A hit on the boundary cycle still belongs to the ending window.
                    acc_count = 1'b1;
                    if (vs_fall) begin
                        if (frame_q == LAST_FRAME) begin
                            state_d = ST_COMPARE;
                        end else begin
                            frame_d = frame_q + FIDX_W'(1);
                        end
                    end
                end
                ST_COMPARE: begin
                    // Latch results; this cycle's hit seeds the next window.
                    latch_result = 1'b1;
                    acc_load     = 1'b1;
                    frame_d      = '0;
                    state_d      = ST_ACCUM;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and frame index registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
        end
    end

    // Per-channel saturating accumulators.
    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        hit_accumulator #(
            .CNT_W (CNT_W)
        ) u_acc (
            .clk      (clk),
            .reset    (reset),
            .clear_i  (acc_clear),
            .load_i   (acc_load),
            .inc_en_i (acc_count),
            .hit_i    (hit_vec[g]),
            .acc_o    (acc[g])
        );
    end

    // Pack the live counts and compare them against the threshold (strict).
    always_comb begin
        count_d = '0;
        over_d  = '0;
        for (int i = 0; i < N_CH; i++) begin
            count_d[i*CNT_W +: CNT_W] = acc[i];
            over_d[i]                 = (acc[i] > threshold);
        end
    end

    // Result latches: update only at the close of the compare cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
            over_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= latch_result;
            if (latch_result) begin
                count_q <= count_d;
                over_q  <= over_d;
            end
        end
    end

    assign count_out    = count_q;
    assign over_thresh  = over_q;
    assign result_valid = valid_q;
    assign frame_idx    = frame_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_frame_window_compare.sv
// Scoreboard bench: dut_a (4 ch, 4-bit counts, 1 frame) and dut_b
// (4 ch, 20-bit counts, 3 frames) share the video inputs but have separate
// enables and thresholds. Expected results are queued at stimulus time and
// popped by a monitor whenever a DUT raises result_valid.
module tb_frame_window_compare;

    logic        clk = 1'b0;
    logic        reset;
    logic        blank_n;
    logic        vs_n;
    logic        en_a, en_b;
    logic [3:0]  hit;
    logic [3:0]  thr_a;
    logic [19:0] thr_b;

    logic [15:0] cnt_a;
    logic [3:0]  ov_a;
    logic        rv_a;
    logic [7:0]  fidx_a;
    logic        busy_a;

    logic [79:0] cnt_b;
    logic [3:0]  ov_b;
    logic        rv_b;
    logic [7:0]  fidx_b;
    logic        busy_b;

    int tests = 0;
    int fails = 0;

    logic [15:0] qa_cnt[$];
    logic [3:0]  qa_ov[$];
    logic [79:0] qb_cnt[$];
    logic [3:0]  qb_ov[$];

    logic [15:0] ea_cnt;
    logic [3:0]  ea_ov;
    logic [79:0] eb_cnt;
    logic [3:0]  eb_ov;

    always #5 clk = ~clk;

    frame_window_compare #(
        .N_CH(4), .CNT_W(4), .FRAMES(1), .FIDX_W(8)
    ) dut_a (
        .clk          (clk),
        .reset        (reset),
        .iVGA_BLANK_N (blank_n),
        .iVGA_VS_N    (vs_n),
        .enable       (en_a),
        .pix_hit      (hit),
        .threshold    (thr_a),
        .count_out    (cnt_a),
        .over_thresh  (ov_a),
        .result_valid (rv_a),
        .frame_idx    (fidx_a),
        .busy         (busy_a)
    );

    frame_window_compare #(
        .N_CH(4), .CNT_W(20), .FRAMES(3), .FIDX_W(8)
    ) dut_b (
        .clk          (clk),
        .reset        (reset),
        .iVGA_BLANK_N (blank_n),
        .iVGA_VS_N    (vs_n),
        .enable       (en_b),
        .pix_hit      (hit),
        .threshold    (thr_b),
        .count_out    (cnt_b),
        .over_thresh  (ov_b),
        .result_valid (rv_b),
        .frame_idx    (fidx_b),
        .busy         (busy_b)
    );

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic vs_pulse();
        blank_n = 1'b0;
        hit     = 4'b0000;
        vs_n    = 1'b0;
        cyc(1);
        vs_n    = 1'b1;
        cyc(1);
    endtask

    task automatic hits(input logic [3:0] m, input int n);
        blank_n = 1'b1;
        hit     = m;
        cyc(n);
        hit     = 4'b0000;
        blank_n = 1'b0;
    endtask

    task automatic push_a(input logic [15:0] c, input logic [3:0] o);
        qa_cnt.push_back(c);
        qa_ov.push_back(o);
    endtask

    // Monitor: every result_valid must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rv_a) begin
            if (qa_cnt.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL a_unexpected_valid: got result_valid=1 count_out=%0h expected no result", cnt_a);
            end else begin
                ea_cnt = qa_cnt.pop_front();
                ea_ov  = qa_ov.pop_front();
                chk("a_count_out", 80'(cnt_a), 80'(ea_cnt));
                chk("a_over_thresh", 80'(ov_a), 80'(ea_ov));
            end
        end
        if (rv_b) begin
            if (qb_cnt.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL b_unexpected_valid: got result_valid=1 count_out=%0h expected no result", cnt_b);
            end else begin
                eb_cnt = qb_cnt.pop_front();
                eb_ov  = qb_ov.pop_front();
                chk("b_count_out", cnt_b, eb_cnt);
                chk("b_over_thresh", 80'(ov_b), 80'(eb_ov));
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; blank_n = 1'b0; vs_n = 1'b1;
        en_a = 1'b0; en_b = 1'b0; hit = 4'b0000;
        thr_a = 4'd0; thr_b = 20'd0;

        // Reset held with a vsync pulse inside it.
        cyc(1);
        vs_n = 1'b0;
        cyc(1);
        vs_n = 1'b1;
        cyc(1);
        @(negedge clk);
        chk("rst_a_count", 80'(cnt_a), 80'd0);
        chk("rst_a_over", 80'(ov_a), 80'd0);
        chk("rst_a_valid", 80'(rv_a), 80'd0);
        chk("rst_a_busy", 80'(busy_a), 80'd0);
        chk("rst_a_fidx", 80'(fidx_a), 80'd0);
        chk("rst_b_count", cnt_b, 80'd0);
        chk("rst_b_busy", 80'(busy_b), 80'd0);

        // Disabled: vsync pulses must not produce results.
        reset = 1'b1;
        cyc(2);
        vs_pulse();
        vs_pulse();
        cyc(2);
        @(negedge clk);
        chk("idle_a_busy", 80'(busy_a), 80'd0);

        // Single frame: ch0=12, ch1=10, ch2=0, ch3=11; blanked ch0 hits ignored.
        thr_a = 4'd10;
        en_a  = 1'b1;
        cyc(2);
        @(negedge clk);
        chk("arm_a_busy", 80'(busy_a), 80'd1);
        vs_pulse();
        for (int k = 0; k < 12; k++) begin
            blank_n = 1'b1;
            hit     = {k < 11, 1'b0, k < 10, 1'b1};
            cyc(1);
        end
        hits(4'b0000, 1);
        blank_n = 1'b0;
        hit     = 4'b0001;
        cyc(5);
        hit     = 4'b0000;
        @(negedge clk);
        chk("single_a_fidx", 80'(fidx_a), 80'd0);
        push_a(16'hB0AC, 4'b1001);
        vs_pulse();
        cyc(2);

        // Saturation: 20 ch2 hits in a 4-bit counter stop at 15.
        thr_a = 4'd14;
        hits(4'b0100, 20);
        push_a(16'h0F00, 4'b0100);
        vs_pulse();
        cyc(2);

        // Boundary: hit on the vsync-fall cycle goes to the old window,
        // hit on the compare cycle seeds the new window.
        thr_a = 4'd0;
        hits(4'b0001, 3);
        push_a(16'h0004, 4'b0001);
        vs_n = 1'b0; blank_n = 1'b1; hit = 4'b0001;
        cyc(1);
        vs_n = 1'b1;
        cyc(1);
        hit = 4'b0000; blank_n = 1'b0;
        cyc(3);
        push_a(16'h0001, 4'b0001);
        vs_pulse();
        cyc(2);

        // Enable drop mid-window: partial count discarded, results held.
        hits(4'b0010, 7);
        en_a = 1'b0;
        cyc(1);
        @(negedge clk);
        chk("drop_a_busy", 80'(busy_a), 80'd0);
        chk("drop_a_count_held", 80'(cnt_a), 80'h0001);
        chk("drop_a_over_held", 80'(ov_a), 80'h1);
        chk("drop_a_fidx", 80'(fidx_a), 80'd0);
        vs_pulse();
        cyc(2);

        // Re-enable: hits before the next vsync fall (ARM) are not counted.
        en_a = 1'b1;
        cyc(1);
        hits(4'b0010, 3);
        @(negedge clk);
        chk("rearm_a_busy", 80'(busy_a), 80'd1);
        vs_pulse();
        hits(4'b0010, 2);
        push_a(16'h0020, 4'b0010);
        vs_pulse();
        cyc(2);

        // Multi-frame on dut_b: 4 ch1 hits per frame over 3 frames.
        en_a  = 1'b0;
        thr_b = 20'd5;
        en_b  = 1'b1;
        cyc(2);
        vs_pulse();
        for (int f = 0; f < 3; f++) begin
            @(negedge clk);
            chk("multi_b_fidx", 80'(fidx_b), 80'(f));
            hits(4'b0010, 4);
            if (f == 2) begin
                qb_cnt.push_back({20'd0, 20'd0, 20'd12, 20'd0});
                qb_ov.push_back(4'b0010);
            end
            vs_pulse();
        end
        @(negedge clk);
        chk("multi_b_fidx_wrap", 80'(fidx_b), 80'd0);
        cyc(2);
        @(negedge clk);
        chk("multi_a_count_held", 80'(cnt_a), 80'h0020);

        // Mid-operation reset clears latched results.
        hits(4'b0001, 2);
        reset = 1'b0;
        cyc(1);
        @(negedge clk);
        chk("mrst_b_count", cnt_b, 80'd0);
        chk("mrst_b_over", 80'(ov_b), 80'd0);
        chk("mrst_b_busy", 80'(busy_b), 80'd0);
        chk("mrst_a_count", 80'(cnt_a), 80'd0);
        reset = 1'b1;
        cyc(2);
        @(negedge clk);
        chk("mrst_b_rearm_busy", 80'(busy_b), 80'd1);
        cyc(3);

        chk("a_pending_results", 80'(qa_cnt.size()), 80'd0);
        chk("b_pending_results", 80'(qb_cnt.size()), 80'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
